// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predictor: branch opcodes,
// 2-bit saturating counter states and the counter step helper.
package branch_pkg;

   typedef enum logic [1:0] {
      BEQ  = 2'b00,
      BNE  = 2'b01,
      BLEZ = 2'b10,
      BGTZ = 2'b11
   } br_op_e;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Move a counter one step toward the resolved direction, saturating at both ends.
   function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      res = ctr;
      if (taken) begin
         if (ctr != ST) res = ctr + 2'd1;
      end else begin
         if (ctr != SNT) res = ctr - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/branch_predictor_br_cond.sv
// Branch condition evaluator: decides the actual direction of a resolving
// conditional branch from its opcode and operands.
module br_cond
   import branch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  br_op_e          op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            taken_o
);

   logic a_le_zero;

   // Signed a <= 0 is "sign bit set or exactly zero"; BGTZ is its complement.
   always_comb begin
      a_le_zero = a_i[XLEN-1] | (a_i == '0);
      taken_o   = 1'b0;
      case (op_i)
         BEQ:  taken_o = (a_i == b_i);
         BNE:  taken_o = (a_i != b_i);
         BLEZ: taken_o = a_le_zero;
         BGTZ: taken_o = ~a_le_zero;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Fetch-side lookup is combinational; resolution in EX updates the table
// and produces a registered flush request plus the corrected next PC.
module branch_predictor
   import branch_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  f_pc,
   output logic             f_pred_taken,
   output logic [XLEN-1:0]  f_pred_target,
   input  logic             ex_valid,
   input  logic [1:0]       ex_op,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  ex_a,
   input  logic [XLEN-1:0]  ex_b,
   input  logic [XLEN-1:0]  ex_target,
   input  logic             ex_pred_taken,
   input  logic [XLEN-1:0]  ex_pred_target,
   output logic             mispredict,
   output logic [XLEN-1:0]  redirect_pc,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mis_count
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic             valid_q [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [1:0]       ctr_q   [ENTRIES];
   logic [XLEN-1:0]  tgt_q   [ENTRIES];

   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;
   logic             ex_taken;
   logic             ex_mis;
   logic [XLEN-1:0]  ex_next_pc;

   logic             mispredict_q;
   logic [XLEN-1:0]  redirect_pc_q;
   logic [CNT_W-1:0] br_count_q;
   logic [CNT_W-1:0] mis_count_q;

   // Word alignment makes the low PC bits meaningless here.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{f_pc[1:0], ex_pc[1:0]};

   // Fetch lookup reads the table as it stood before this cycle's update.
   always_comb begin
      f_idx         = f_pc[IDX_W+1:2];
      f_tag         = f_pc[XLEN-1:IDX_W+2];
      f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
      f_pred_taken  = f_hit & ctr_q[f_idx][1];
      f_pred_target = f_pred_taken ? tgt_q[f_idx] : f_pc + XLEN'(4);
   end

   br_cond #(
      .XLEN (XLEN)
   ) u_br_cond (
      .op_i    (br_op_e'(ex_op)),
      .a_i     (ex_a),
      .b_i     (ex_b),
      .taken_o (ex_taken)
   );

   // Resolution: table hit, mispredict condition and the correct next PC.
   always_comb begin
      ex_idx     = ex_pc[IDX_W+1:2];
      ex_tag     = ex_pc[XLEN-1:IDX_W+2];
      ex_hit     = valid_q[ex_idx] && (ex_tag_match(ex_idx));
      ex_mis     = (ex_taken != ex_pred_taken) ||
                   (ex_taken && ex_pred_taken && (ex_pred_target != ex_target));
      ex_next_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);
   end

   function automatic logic ex_tag_match(input logic [IDX_W-1:0] idx);
      return tag_q[idx] == ex_tag;
   endfunction

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
         logic sel;
         assign sel = ex_valid && (ex_idx == IDX_W'(gi));

         // Per-entry update: step on hit, allocate as weakly-taken on a taken miss.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               valid_q[gi] <= 1'b0;
               tag_q[gi]   <= '0;
               ctr_q[gi]   <= WNT;
               tgt_q[gi]   <= '0;
            end else if (sel) begin
               if (ex_hit) begin
                  ctr_q[gi] <= ctr_step(ctr_q[gi], ex_taken);
                  if (ex_taken) tgt_q[gi] <= ex_target;
               end else if (ex_taken) begin
                  valid_q[gi] <= 1'b1;
                  tag_q[gi]   <= ex_tag;
                  ctr_q[gi]   <= WT;
                  tgt_q[gi]   <= ex_target;
               end
            end
         end
      end
   endgenerate

   // Flush request, redirect PC and saturating statistics, one cycle after EX.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mispredict_q  <= 1'b0;
         redirect_pc_q <= '0;
         br_count_q    <= '0;
         mis_count_q   <= '0;
      end else begin
         mispredict_q <= ex_valid & ex_mis;
         if (ex_valid) redirect_pc_q <= ex_next_pc;
         if (ex_valid && (br_count_q != '1)) br_count_q <= br_count_q + CNT_W'(1);
         if (ex_valid && ex_mis && (mis_count_q != '1)) mis_count_q <= mis_count_q + CNT_W'(1);
      end
   end

   assign mispredict  = mispredict_q;
   assign redirect_pc = redirect_pc_q;
   assign br_count    = br_count_q;
   assign mis_count   = mis_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a plain-arithmetic reference model of
// the predictor table and statistics, checked against the DUT every cycle,
// plus literal expectations at key points of the directed sequence.
module tb_branch_predictor;
   import branch_pkg::*;

   localparam int XLEN    = 32;
   localparam int ENTRIES = 16;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;

   logic             clk;
   logic             reset;
   logic [XLEN-1:0]  f_pc;
   logic             f_pred_taken;
   logic [XLEN-1:0]  f_pred_target;
   logic             ex_valid;
   logic [1:0]       ex_op;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_a;
   logic [XLEN-1:0]  ex_b;
   logic [XLEN-1:0]  ex_target;
   logic             ex_pred_taken;
   logic [XLEN-1:0]  ex_pred_target;
   logic             mispredict;
   logic [XLEN-1:0]  redirect_pc;
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] mis_count;

   int checks   = 0;
   int failures = 0;

   branch_predictor #(
      .XLEN    (XLEN),
      .ENTRIES (ENTRIES),
      .CNT_W   (CNT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .f_pc           (f_pc),
      .f_pred_taken   (f_pred_taken),
      .f_pred_target  (f_pred_target),
      .ex_valid       (ex_valid),
      .ex_op          (ex_op),
      .ex_pc          (ex_pc),
      .ex_a           (ex_a),
      .ex_b           (ex_b),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .br_count       (br_count),
      .mis_count      (mis_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit          m_valid [ENTRIES];
   logic [31:0] m_tag   [ENTRIES];
   int          m_ctr   [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   logic        m_mis;
   logic [31:0] m_redir;
   int          m_br;
   int          m_misc;

   function automatic int m_index(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic logic [31:0] m_tagof(input logic [31:0] pc);
      return pc / (4 * ENTRIES);
   endfunction

   function automatic logic m_taken(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         2'd0:    return a == b;
         2'd1:    return a != b;
         2'd2:    return $signed(a) <= 0;
         default: return $signed(a) > 0;
      endcase
   endfunction

   task automatic m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
      int i;
      i = m_index(pc);
      t = m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
      tg = t ? m_tgt[i] : pc + 32'd4;
   endtask

   task automatic m_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_ctr[i]   = 1;
         m_tgt[i]   = '0;
      end
      m_mis   = 1'b0;
      m_redir = '0;
      m_br    = 0;
      m_misc  = 0;
   endtask

   task automatic m_apply();
      logic t;
      int   i;
      if (!ex_valid) begin
         m_mis = 1'b0;
      end else begin
         t = m_taken(ex_op, ex_a, ex_b);
         m_mis = (t != ex_pred_taken) || (t && ex_pred_taken && (ex_pred_target != ex_target));
         m_redir = t ? ex_target : ex_pc + 32'd4;
         if (m_br < CNT_MAX) m_br++;
         if (m_mis && m_misc < CNT_MAX) m_misc++;
         i = m_index(ex_pc);
         if (m_valid[i] && m_tag[i] == m_tagof(ex_pc)) begin
            m_ctr[i] = t ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                         : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
            if (t) m_tgt[i] = ex_target;
         end else if (t) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = m_tagof(ex_pc);
            m_ctr[i]   = 2;
            m_tgt[i]   = ex_target;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Every cycle, away from the active edge, compare all outputs with the model.
   always @(negedge clk) begin
      logic        et;
      logic [31:0] etg;
      m_lookup(f_pc, et, etg);
      chk("cyc_f_pred_taken",  32'(f_pred_taken),  32'(et));
      chk("cyc_f_pred_target", f_pred_target,      etg);
      chk("cyc_mispredict",    32'(mispredict),    32'(m_mis));
      chk("cyc_redirect_pc",   redirect_pc,        m_redir);
      chk("cyc_br_count",      32'(br_count),      32'(m_br));
      chk("cyc_mis_count",     32'(mis_count),     32'(m_misc));
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_ex(input logic v, input logic [1:0] op, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptg);
      ex_valid       = v;
      ex_op          = op;
      ex_pc          = pc;
      ex_a           = a;
      ex_b           = b;
      ex_target      = tgt;
      ex_pred_taken  = pt;
      ex_pred_target = ptg;
   endtask

   task automatic idle();
      set_ex(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   // Resolve a branch carrying whatever the model says fetch predicted for it.
   task automatic br_pred(input logic [1:0] op, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt);
      logic        pt;
      logic [31:0] ptg;
      m_lookup(pc, pt, ptg);
      set_ex(1'b1, op, pc, a, b, tgt, pt, ptg);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) m_apply();
      #1;
   endtask

   // Drive f_pc and check the combinational prediction against literals.
   task automatic chk_fetch(input string name, input logic [31:0] pc,
                            input logic t, input logic [31:0] tg);
      f_pc = pc;
      #1;
      chk({name, "_taken"},  32'(f_pred_taken), 32'(t));
      chk({name, "_target"}, f_pred_target,     tg);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1;
      f_pc  = 32'h40;
      idle();
      m_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;

      // Reset state
      chk_fetch("rst_lookup", 32'h40, 1'b0, 32'h44);
      chk("rst_mispredict", 32'(mispredict), 32'h0);
      chk("rst_redirect",   redirect_pc,     32'h0);
      chk("rst_br_count",   32'(br_count),   32'h0);

      // BNE taken, not predicted: flush to target, then learned
      set_ex(1'b1, BNE, 32'h40, 32'd5, 32'd3, 32'h20, 1'b0, 32'h44);
      tick();
      idle();
      chk("bne_mispredict", 32'(mispredict), 32'h1);
      chk("bne_redirect",   redirect_pc,     32'h20);
      chk_fetch("bne_learned", 32'h40, 1'b1, 32'h20);
      tick();
      chk("pulse_clears",   32'(mispredict), 32'h0);
      chk("redirect_holds", redirect_pc,     32'h20);

      // BEQ taken x3 (counter to ST), then not-taken (WT, still predicts taken)
      for (int i = 0; i < 3; i++) begin
         br_pred(BEQ, 32'h40, 32'd7, 32'd7, 32'h20);
         tick();
      end
      br_pred(BEQ, 32'h40, 32'd7, 32'd8, 32'h20);
      tick();
      idle();
      chk("beq_nt_mispredict", 32'(mispredict), 32'h1);
      chk("beq_nt_redirect",   redirect_pc,     32'h44);
      chk("beq_br_count",      32'(br_count),   32'd5);
      chk("beq_mis_count",     32'(mis_count),  32'd2);
      chk_fetch("ctr_wt", 32'h40, 1'b1, 32'h20);
      br_pred(BEQ, 32'h40, 32'd7, 32'd8, 32'h20);
      tick();
      idle();
      chk("beq_mis_count2", 32'(mis_count), 32'd3);
      chk_fetch("ctr_wnt", 32'h40, 1'b0, 32'h44);

      // Signed zero-compare branches
      set_ex(1'b1, BLEZ, 32'h110, 32'h80000000, 32'h0, 32'h180, 1'b0, 32'h114);
      tick();
      chk("blez_neg_mis",   32'(mispredict), 32'h1);
      chk("blez_neg_redir", redirect_pc,     32'h180);
      set_ex(1'b1, BGTZ, 32'h114, 32'h0, 32'h5, 32'h190, 1'b0, 32'h118);
      tick();
      chk("bgtz_zero_mis",   32'(mispredict), 32'h0);
      chk("bgtz_zero_redir", redirect_pc,     32'h118);
      set_ex(1'b1, BLEZ, 32'h118, 32'h1, 32'h0, 32'h1a0, 1'b0, 32'h11c);
      tick();
      idle();
      chk("blez_pos_mis",   32'(mispredict), 32'h0);
      chk("blez_pos_redir", redirect_pc,     32'h11c);
      chk_fetch("nt_miss_no_alloc", 32'h118, 1'b0, 32'h11c);

      // Aliasing: 0x80 shares 0x40's index and evicts it
      br_pred(BEQ, 32'h40, 32'd1, 32'd1, 32'h20);
      tick();
      idle();
      chk_fetch("pre_evict_hit", 32'h40, 1'b1, 32'h20);
      br_pred(BEQ, 32'h80, 32'd1, 32'd1, 32'h300);
      tick();
      idle();
      chk_fetch("evicted_miss", 32'h40, 1'b0, 32'h44);
      chk_fetch("evictor_hit",  32'h80, 1'b1, 32'h300);

      // Right direction, wrong target
      set_ex(1'b1, BEQ, 32'h80, 32'd2, 32'd2, 32'h104, 1'b1, 32'h100);
      tick();
      idle();
      chk("tgt_mis",   32'(mispredict), 32'h1);
      chk("tgt_redir", redirect_pc,     32'h104);

      // Same-cycle lookup and update of one entry
      set_ex(1'b1, BNE, 32'h204, 32'd1, 32'd2, 32'h240, 1'b0, 32'h208);
      chk_fetch("same_cycle_old", 32'h204, 1'b0, 32'h208);
      tick();
      idle();
      chk_fetch("same_cycle_new", 32'h204, 1'b1, 32'h240);

      // Fall-through wraps modulo 2^32
      chk_fetch("pc_wrap", 32'hFFFFFFFC, 1'b0, 32'h0);

      // Back-to-back resolutions; statistics saturate
      for (int i = 0; i < 8; i++) begin
         set_ex(1'b1, 2'(i % 4), 32'h400 + 32'((i % 3) * 4),
                (i % 2 == 1) ? 32'(i) : -32'(i), 32'(i % 3),
                32'h800 + 32'(i * 16), (i % 3 == 0),
                (i == 6) ? 32'h804 : 32'h800 + 32'(i * 16));
         tick();
      end
      idle();
      chk("br_count_sat", 32'(br_count), 32'd15);

      // Reset during a mispredicting resolution discards it
      set_ex(1'b1, BEQ, 32'h80, 32'd2, 32'd2, 32'h104, 1'b1, 32'h100);
      reset = 1'b1;
      m_reset();
      #1;
      chk("reset_async_mis", 32'(mispredict), 32'h0);
      tick();
      reset = 1'b0;
      idle();
      chk("reset_mid_mis",   32'(mispredict), 32'h0);
      chk("reset_mid_redir", redirect_pc,     32'h0);
      chk("reset_mid_br",    32'(br_count),   32'h0);
      chk_fetch("post_reset_80",  32'h80,  1'b0, 32'h84);
      chk_fetch("post_reset_204", 32'h204, 1'b0, 32'h208);
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
